fsub_issue: RTL and testbench
=============================

# fsub_issue

Sequential issue/capture stage wrapped around the combinational `fsub` datapath in the FPU. It accepts FP32 add/subtract requests over a valid/ready handshake and converts add into subtract by flipping the sign of `x2`. It holds the operands stable on the `fsub` inputs for a fixed multicycle window, then registers `y`/`ovf` into an output slot with its own valid/ready handshake and a sticky overflow flag. The FPU top instantiates it next to `fsub`, and this block drives `fsub`'s `x1`/`x2` directly.

## Interface
- `LATENCY`, default 2: cycles from accept to result capture, legal 1..15; sets the multicycle window granted to `fsub`.
- `TAG_W`, default 4: width of the opaque request tag.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  request accepted on an edge where `in_valid && in_ready`.
- `in_op`  in  1  0 = `x1 - x2`, 1 = `x1 + x2`.
- `in_x1`, `in_x2`  in  32  FP32 operands.
- `in_tag`  in  TAG_W  returned unchanged with the result.
- `sub_x1`, `sub_x2`  out  32  registered operands to `fsub`.
- `sub_y`  in  32  `fsub` result.
- `sub_ovf`  in  1  `fsub` overflow.
- `out_valid`  out  1  result slot full.
- `out_ready`  in  1  consumer takes the result on an edge where `out_valid && out_ready`.
- `out_y`  out  32  captured result.
- `out_ovf`  out  1  captured overflow for this result.
- `out_tag`  out  TAG_W  tag of this result.
- `ovf_sticky`  out  1  OR of all captured `out_ovf` since the last clear.
- `ovf_clr`  in  1  clears `ovf_sticky`.
- `busy`  out  1  state is not IDLE.

## Operation
- State machine has three states: IDLE, EXEC, DONE.
- **IDLE:** `in_ready` = 1. On accept:
  - `sub_x1` <= `in_x1`.
  - `sub_x2` <= `in_op ? {~in_x2[31], in_x2[30:0]} : in_x2`. The sign flip is unconditional, including NaN and Inf.
  - Latch the tag.
  - `cnt` <= `LATENCY-1`.
  - Go to EXEC.
- **EXEC:** `in_ready` = 0.
  - If `cnt != 0`, decrement `cnt`.
  - If `cnt == 0`, capture `sub_y`, `sub_ovf` and the tag into the out registers, set `out_valid`, and go to DONE.
- **DONE:** `out_valid` = 1 and the outputs are frozen. `in_ready` = `out_ready` (combinational).
  - On output handshake with no new accept: clear `out_valid` and go to IDLE.
  - On output handshake with a simultaneous accept: load the new operands and go to EXEC; `out_valid` drops on the same edge.
- `sub_x1`/`sub_x2` change only on accept, so they are stable for the whole EXEC window and through DONE.
- `ovf_sticky`:
  - Set on a capture with `sub_ovf` = 1.
  - Cleared by `ovf_clr`.
  - If set and clear occur on the same edge, set wins.
- `cnt` is 4 bits. `LATENCY` = 0 or >15 is illegal and is rejected by an elaboration-time check.

## Timing
- Accept at edge N puts the operands on `sub_x*` from cycle N. Capture is at edge N+LATENCY, and `out_valid` is high from that cycle.
- Sustained throughput with `out_ready` held high is one result per LATENCY+1 cycles.
- Backpressure: `out_valid`, `out_y`, `out_ovf` and `out_tag` hold indefinitely while `out_ready` = 0. No second request is accepted during that time.
- Reset values:
  - State is IDLE.
  - `out_valid`, `out_y`, `out_ovf`, `out_tag`, `sub_x1`, `sub_x2`, `cnt` and `ovf_sticky` are all 0.
  - `busy` = 0.
  - `in_ready` is forced to 0 while `rst` is high.
- Reset in EXEC or DONE drops the transaction: no `out_valid` follows, and the next cycle is IDLE.
- `ovf_clr` during reset has no effect beyond the reset itself.

## Structure
- Shared package `fpu_pkg` holds:
  - FP32 field constants: `FP_W`=32, `EXP_W`=8, `MAN_W`=23, `SIGN_BIT`=31.
  - The state enum `issue_state_t` {IDLE, EXEC, DONE}.
- No sub-module is needed: FSM, countdown counter and registers live in one module. `fsub` is instantiated beside it in the FPU top, not inside.

## Test plan
- Sub: `x1`=0x40400000, `x2`=0x3F800000, `op`=0, `LATENCY`=2. Required: `out_y`=0x40000000, `out_ovf`=0, `out_valid` two cycles after accept, tag echoed.
- Add: `x1`=0x3F800000, `x2`=0x3F800000, `op`=1. Required: `sub_x2`=0xBF800000, `out_y`=0x40000000.
- Overflow: `x1`=0x7F7FFFFF, `x2`=0xFF7FFFFF, `op`=0. Required: `out_y`=0x7F800000, `out_ovf`=1, `ovf_sticky`=1. Then pulse `ovf_clr` on the same edge as another overflow capture: `ovf_sticky` stays 1. A later `ovf_clr` alone clears it.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE with `in_valid`=1. Required: outputs frozen and `in_ready`=0 throughout. Raise `out_ready`: handshake and new accept on the same edge, next result LATENCY cycles later.
- Back-to-back: `out_ready`=1, 4 requests with `LATENCY`=3. Required: results every 4 cycles, in order, tags 0..3.
- Reset mid-EXEC: assert `rst` one cycle after accept. Required: no `out_valid` for that request; `in_ready`=1 the cycle after `rst` drops.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: FP32 field layout and the issue-stage state encoding.
package fpu_pkg;

    localparam int FP_W     = 32;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int SIGN_BIT = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } issue_state_t;

    // Raw sign toggle; no special-casing of NaN/Inf.
    function automatic logic [FP_W-1:0] flip_sign(input logic [FP_W-1:0] x);
        return {~x[SIGN_BIT], x[SIGN_BIT-1:0]};
    endfunction

endpackage

// File: rtl/fsub_issue.sv
// Issue/capture stage around the combinational fsub datapath: holds operands for a
// fixed multicycle window, then captures the result into a handshaked output slot.
module fsub_issue
    import fpu_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [FP_W-1:0]  in_x1,
    input  logic [FP_W-1:0]  in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [FP_W-1:0]  sub_x1,
    output logic [FP_W-1:0]  sub_x2,
    input  logic [FP_W-1:0]  sub_y,
    input  logic             sub_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_y,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag,
    output logic             ovf_sticky,
    input  logic             ovf_clr,
    output logic             busy
);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("fsub_issue: LATENCY must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    issue_state_t     state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [FP_W-1:0]  sub_x1_reg, sub_x1_next;
    logic [FP_W-1:0]  sub_x2_reg, sub_x2_next;
    logic [TAG_W-1:0] tag_reg, tag_next;
    logic             out_valid_reg, out_valid_next;
    logic [FP_W-1:0]  out_y_reg, out_y_next;
    logic             out_ovf_reg, out_ovf_next;
    logic [TAG_W-1:0] out_tag_reg, out_tag_next;
    logic             sticky_reg, sticky_next;

    logic ready_c;
    logic accept;
    logic take;
    logic capture;

    // A DONE slot can be refilled on the same edge the consumer drains it.
    always_comb begin
        ready_c = 1'b0;
        if (!rst) begin
            case (state_reg)
                IDLE:    ready_c = 1'b1;
                DONE:    ready_c = out_ready;
                default: ready_c = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && ready_c;
    assign take   = out_valid_reg && out_ready;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        sub_x1_next    = sub_x1_reg;
        sub_x2_next    = sub_x2_reg;
        tag_next       = tag_reg;
        out_valid_next = out_valid_reg;
        out_y_next     = out_y_reg;
        out_ovf_next   = out_ovf_reg;
        out_tag_next   = out_tag_reg;
        capture        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    capture        = 1'b1;
                    out_y_next     = sub_y;
                    out_ovf_next   = sub_ovf;
                    out_tag_next   = tag_reg;
                    out_valid_next = 1'b1;
                    state_next     = DONE;
                end
            end
            DONE: begin
                if (take) begin
                    out_valid_next = 1'b0;
                    state_next     = accept ? EXEC : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Operand load is shared by the IDLE and DONE accept paths.
        if (accept) begin
            sub_x1_next = in_x1;
            sub_x2_next = in_op ? flip_sign(in_x2) : in_x2;
            tag_next    = in_tag;
            cnt_next    = CNT_INIT;
        end
    end

    // Set has priority over clear so a same-edge overflow is never lost.
    always_comb begin
        sticky_next = sticky_reg;
        if (capture && sub_ovf) begin
            sticky_next = 1'b1;
        end else if (ovf_clr) begin
            sticky_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            sub_x1_reg    <= '0;
            sub_x2_reg    <= '0;
            tag_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_y_reg     <= '0;
            out_ovf_reg   <= 1'b0;
            out_tag_reg   <= '0;
            sticky_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            sub_x1_reg    <= sub_x1_next;
            sub_x2_reg    <= sub_x2_next;
            tag_reg       <= tag_next;
            out_valid_reg <= out_valid_next;
            out_y_reg     <= out_y_next;
            out_ovf_reg   <= out_ovf_next;
            out_tag_reg   <= out_tag_next;
            sticky_reg    <= sticky_next;
        end
    end

    assign in_ready   = ready_c;
    assign sub_x1     = sub_x1_reg;
    assign sub_x2     = sub_x2_reg;
    assign out_valid  = out_valid_reg;
    assign out_y      = out_y_reg;
    assign out_ovf    = out_ovf_reg;
    assign out_tag    = out_tag_reg;
    assign ovf_sticky = sticky_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_fsub_issue.sv
// Bench for fsub_issue: two instances (LATENCY 2 and 3), a transaction-level model,
// a per-cycle compare process and directed scenarios with literal expectations.
module tb_fsub_issue;

    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             in_valid [2];
    logic             in_ready [2];
    logic             in_op [2];
    logic [31:0]      in_x1 [2];
    logic [31:0]      in_x2 [2];
    logic [TAG_W-1:0] in_tag [2];
    logic [31:0]      sub_x1 [2];
    logic [31:0]      sub_x2 [2];
    logic [31:0]      sub_y [2];
    logic             sub_ovf [2];
    logic             out_valid [2];
    logic             out_ready [2];
    logic [31:0]      out_y [2];
    logic             out_ovf [2];
    logic [TAG_W-1:0] out_tag [2];
    logic             ovf_sticky [2];
    logic             ovf_clr [2];
    logic             busy [2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Stand-in for fsub: exact results for the directed vectors, a fixed mixing
    // function elsewhere. Returns {ovf, y}.
    function automatic logic [32:0] fsub_ref(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4040_0000 && b == 32'h3F80_0000) return {1'b0, 32'h4000_0000};
        if (a == 32'h3F80_0000 && b == 32'hBF80_0000) return {1'b0, 32'h4000_0000};
        if (a == 32'h7F7F_FFFF && b == 32'hFF7F_FFFF) return {1'b1, 32'h7F80_0000};
        return {1'b0, a ^ {b[15:0], b[31:16]}};
    endfunction

    assign {sub_ovf[0], sub_y[0]} = fsub_ref(sub_x1[0], sub_x2[0]);
    assign {sub_ovf[1], sub_y[1]} = fsub_ref(sub_x1[1], sub_x2[1]);

    fsub_issue #(.LATENCY(2), .TAG_W(TAG_W)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_op(in_op[0]),
        .in_x1(in_x1[0]), .in_x2(in_x2[0]), .in_tag(in_tag[0]),
        .sub_x1(sub_x1[0]), .sub_x2(sub_x2[0]), .sub_y(sub_y[0]), .sub_ovf(sub_ovf[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_y(out_y[0]),
        .out_ovf(out_ovf[0]), .out_tag(out_tag[0]), .ovf_sticky(ovf_sticky[0]),
        .ovf_clr(ovf_clr[0]), .busy(busy[0])
    );

    fsub_issue #(.LATENCY(3), .TAG_W(TAG_W)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_op(in_op[1]),
        .in_x1(in_x1[1]), .in_x2(in_x2[1]), .in_tag(in_tag[1]),
        .sub_x1(sub_x1[1]), .sub_x2(sub_x2[1]), .sub_y(sub_y[1]), .sub_ovf(sub_ovf[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_y(out_y[1]),
        .out_ovf(out_ovf[1]), .out_tag(out_tag[1]), .ovf_sticky(ovf_sticky[1]),
        .ovf_clr(ovf_clr[1]), .busy(busy[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit               m_pend [2];
    bit               m_full [2];
    int               m_rem [2];
    logic [31:0]      m_x1 [2];
    logic [31:0]      m_x2 [2];
    logic [TAG_W-1:0] m_ptag [2];
    logic [31:0]      m_y [2];
    bit               m_ovf [2];
    logic [TAG_W-1:0] m_tag [2];
    bit               m_sticky [2];
    bit               started = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic bit m_ready(input int d);
        return !rst && !m_pend[d] && (!m_full[d] || out_ready[d]);
    endfunction

    bit          mo_acc, mo_take, mo_cap;
    logic [32:0] mo_res;

    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_pend[d] = 0; m_full[d] = 0; m_rem[d] = 0;
                m_x1[d] = '0; m_x2[d] = '0; m_ptag[d] = '0;
                m_y[d] = '0; m_ovf[d] = 0; m_tag[d] = '0; m_sticky[d] = 0;
            end else begin
                mo_acc  = in_valid[d] && m_ready(d);
                mo_take = m_full[d] && out_ready[d];
                mo_cap  = 0;
                if (m_pend[d]) begin
                    m_rem[d]--;
                    if (m_rem[d] == 0) begin
                        mo_cap    = 1;
                        m_pend[d] = 0;
                    end
                end
                if (mo_take) begin
                    $display("xfer dut=%0d tag=%0d y=%h ovf=%0d cycle=%0d",
                             d, m_tag[d], m_y[d], m_ovf[d], cyc);
                    m_full[d] = 0;
                end
                if (mo_cap) begin
                    mo_res    = fsub_ref(m_x1[d], m_x2[d]);
                    m_full[d] = 1;
                    m_y[d]    = mo_res[31:0];
                    m_ovf[d]  = mo_res[32];
                    m_tag[d]  = m_ptag[d];
                    m_sticky[d] = m_sticky[d] | mo_res[32];
                end else if (ovf_clr[d]) begin
                    m_sticky[d] = 0;
                end
                if (mo_acc) begin
                    m_x1[d]   = in_x1[d];
                    m_x2[d]   = in_op[d] ? (in_x2[d] ^ 32'h8000_0000) : in_x2[d];
                    m_ptag[d] = in_tag[d];
                    m_rem[d]  = lat_of(d);
                    m_pend[d] = 1;
                end
            end
        end
        started = 1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                chk("in_ready", 32'(in_ready[d]), 32'(m_ready(d)));
                chk("busy", 32'(busy[d]), 32'(m_pend[d] || m_full[d]));
                chk("out_valid", 32'(out_valid[d]), 32'(m_full[d]));
                chk("ovf_sticky", 32'(ovf_sticky[d]), 32'(m_sticky[d]));
                chk("sub_x1", sub_x1[d], m_x1[d]);
                chk("sub_x2", sub_x2[d], m_x2[d]);
                if (m_full[d]) begin
                    chk("out_y", out_y[d], m_y[d]);
                    chk("out_ovf", 32'(out_ovf[d]), 32'(m_ovf[d]));
                    chk("out_tag", 32'(out_tag[d]), 32'(m_tag[d]));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic op, input logic [31:0] x1,
                        input logic [31:0] x2, input logic [TAG_W-1:0] tag,
                        output int acc_cyc);
        bit done = 0;
        in_valid[d] = 1; in_op[d] = op; in_x1[d] = x1; in_x2[d] = x2; in_tag[d] = tag;
        acc_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            if (in_ready[d]) begin
                step();
                acc_cyc = cyc;
                done = 1;
                break;
            end
            step();
        end
        in_valid[d] = 0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL accept_timeout: dut=%0d tag=%0d not accepted", d, tag);
        end
    endtask

    task automatic wait_valid(input int d, output int n);
        n = 0;
        while (!out_valid[d] && n < 40) begin
            step();
            n++;
        end
        if (!out_valid[d]) begin
            checks++; errors++;
            $display("FAIL result_timeout: dut=%0d no out_valid after %0d cycles", d, n);
        end
    endtask

    task automatic drain(input int d);
        out_ready[d] = 1;
        step();
        out_ready[d] = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, prev, n;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 0; in_op[d] = 0; in_x1[d] = '0; in_x2[d] = '0;
            in_tag[d] = '0; out_ready[d] = 0; ovf_clr[d] = 0;
        end
        rst = 1;
        repeat (3) step();
        chk("rst_in_ready", 32'(in_ready[0]), 32'd0);
        rst = 0;
        #1;
        chk("reset_out_valid", 32'(out_valid[0]), 32'd0);
        chk("reset_sub_x1", sub_x1[0], 32'd0);
        chk("reset_busy", 32'(busy[0]), 32'd0);
        chk("idle_in_ready", 32'(in_ready[0]), 32'd1);

        // Subtract 3.0 - 1.0
        send(0, 1'b0, 32'h4040_0000, 32'h3F80_0000, 4'd5, acc);
        wait_valid(0, n);
        chk("sub_latency", 32'(n), 32'd2);
        chk("sub_y", out_y[0], 32'h4000_0000);
        chk("sub_ovf", 32'(out_ovf[0]), 32'd0);
        chk("sub_tag", 32'(out_tag[0]), 32'd5);
        drain(0);

        // Add 1.0 + 1.0 via sign flip of x2
        send(0, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 4'd6, acc);
        chk("add_sub_x2", sub_x2[0], 32'hBF80_0000);
        wait_valid(0, n);
        chk("add_y", out_y[0], 32'h4000_0000);
        drain(0);

        // Overflow and sticky behaviour
        send(0, 1'b0, 32'h7F7F_FFFF, 32'hFF7F_FFFF, 4'd1, acc);
        wait_valid(0, n);
        chk("ovf_y", out_y[0], 32'h7F80_0000);
        chk("ovf_flag", 32'(out_ovf[0]), 32'd1);
        chk("ovf_sticky_set", 32'(ovf_sticky[0]), 32'd1);
        drain(0);
        ovf_clr[0] = 1; step(); ovf_clr[0] = 0;
        chk("ovf_clr_alone", 32'(ovf_sticky[0]), 32'd0);
        send(0, 1'b0, 32'h7F7F_FFFF, 32'hFF7F_FFFF, 4'd2, acc);
        step();
        ovf_clr[0] = 1;
        step();
        ovf_clr[0] = 0;
        chk("ovf_set_wins_valid", 32'(out_valid[0]), 32'd1);
        chk("ovf_set_wins", 32'(ovf_sticky[0]), 32'd1);
        drain(0);
        ovf_clr[0] = 1; step(); ovf_clr[0] = 0;
        chk("ovf_clr_later", 32'(ovf_sticky[0]), 32'd0);

        // Backpressure in DONE with a pending request
        send(0, 1'b0, 32'h4040_0000, 32'h3F80_0000, 4'd7, acc);
        wait_valid(0, n);
        in_valid[0] = 1; in_op[0] = 1; in_x1[0] = 32'h3F80_0000;
        in_x2[0] = 32'h3F80_0000; in_tag[0] = 4'd8;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 32'(out_valid[0]), 32'd1);
            chk("bp_y", out_y[0], 32'h4000_0000);
            chk("bp_tag", 32'(out_tag[0]), 32'd7);
            chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
        end
        out_ready[0] = 1;
        #1;
        chk("bp_release_ready", 32'(in_ready[0]), 32'd1);
        step();
        in_valid[0] = 0;
        out_ready[0] = 0;
        chk("bp_valid_drop", 32'(out_valid[0]), 32'd0);
        chk("bp_busy", 32'(busy[0]), 32'd1);
        wait_valid(0, n);
        chk("bp_next_latency", 32'(n), 32'd2);
        chk("bp_next_tag", 32'(out_tag[0]), 32'd8);
        chk("bp_next_y", out_y[0], 32'h4000_0000);
        drain(0);

        // Reset one cycle after accept drops the transaction
        send(0, 1'b0, 32'h4040_0000, 32'h3F80_0000, 4'd9, acc);
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("rst_exec_in_ready", 32'(in_ready[0]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_exec_no_valid", 32'(out_valid[0]), 32'd0);
        end

        // Back-to-back on the LATENCY=3 instance
        out_ready[1] = 1;
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            send(1, i[0], 32'h4100_0000 + 32'(i), 32'h3F00_0000 + 32'(i * 3),
                 TAG_W'(i), acc);
            if (prev >= 0) chk("b2b_spacing", 32'(acc - prev), 32'd4);
            wait_valid(1, n);
            chk("b2b_latency", 32'(n), 32'd3);
            chk("b2b_tag", 32'(out_tag[1]), 32'(i));
            prev = acc;
        end
        step();
        chk("b2b_drained", 32'(out_valid[1]), 32'd0);
        out_ready[1] = 0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
